counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving idle cycles (range 1-15) between load and count enable, covering the counter's 20 ns setup.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  stop request, honoured in every state.
REQ-006 SHALL have port dir_req  input  1  requested direction (1 up, 0 down), captured with start.
REQ-007 SHALL have port preset  input  8  value loaded into the cascaded counter pair, captured with start.
REQ-008 SHALL have port cnt_rco_n  input  1  ripple carry-out of the upper 74169 stage in the cascade.
REQ-009 SHALL have port cnt_load_n  output  1  load strobe to both stages.
REQ-010 SHALL have port cnt_ent_n  output  1  ENT to the lower stage.
REQ-011 SHALL have port cnt_enp_n  output  1  ENP to both stages.
REQ-012 SHALL have port cnt_dir  output  1  direction to both stages.
REQ-013 SHALL have port cnt_p  output  8  parallel data to the stages ([3:0] lower, [7:4] upper).
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-016 SHALL have port wraps  output  8  terminal-count events since the last start.

Function
REQ-017 SHALL implement states IDLE, LOAD, SETTLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: start=1 and abort=0 at an edge SHALL capture preset/dir_req into cnt_p/cnt_dir, clear wraps, and enter LOAD.
REQ-019 LOAD SHALL last exactly one cycle with cnt_load_n=0 and both enables high, then enter SETTLE.
REQ-020 SETTLE SHALL hold cnt_load_n=1 and both enables high for exactly SETTLE_CYCLES cycles, then enter RUN.
REQ-021 RUN SHALL drive cnt_ent_n=0, cnt_enp_n=0, cnt_load_n=1.
REQ-022 cnt_rco_n SHALL be evaluated only in RUN; its low state in LOAD/SETTLE (the counter forces RCO low while loading) SHALL be ignored.
REQ-023 cnt_rco_n=0 sampled in RUN SHALL be a terminal event: wraps increments, saturating at 255.
REQ-024 start asserted while busy=1 SHALL be ignored; cnt_p and cnt_dir SHALL stay stable while busy=1.
REQ-025 abort=1 at any edge SHALL move to IDLE next cycle with enables high and cnt_load_n=1, with no done pulse; abort overrides a simultaneous start or terminal event, wraps excepted (the event still counts).
REQ-026 DONE SHALL last one cycle with done=1 and enables high, then return to IDLE.
REQ-027 Timing: start seen at edge N gives cnt_load_n low from N to N+1, enables low from edge N+1+SETTLE_CYCLES.
REQ-028 Preset 8'hFF counting up SHALL yield a terminal event on the first RUN edge.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, cnt_load_n=1, cnt_ent_n=1, cnt_enp_n=1, cnt_dir=1, cnt_p=0, busy=0, done=0, wraps=0, including mid-RUN.
REQ-030 Release of rst_n SHALL take effect at the next rising clk; no start sampled on that same edge is lost or double-counted.

Configuration
REQ-031 Macro COUNTER_SEQ_AUTO_RELOAD_EN defined: terminal event in RUN SHALL go to LOAD (reload captured preset, same direction), repeating until abort; done never pulses.
REQ-032 Macro undefined: terminal event in RUN SHALL go to DONE, then IDLE.

Verification
REQ-033 Reset mid-RUN (rst_n low for 3 ns, asynchronous to clk) -> all outputs at reset values before the next edge.
REQ-034 preset=8'hF0, dir_req=1, SETTLE_CYCLES=1, macro undefined, counter model attached -> load_n low 1 cycle, 1 settle cycle, 16 RUN cycles, wraps=1, done pulse, busy low after.
REQ-035 preset=8'hFF up -> terminal on first RUN edge, wraps=1, done next cycle.
REQ-036 abort in 5th RUN cycle with start held high -> IDLE, enables high, no done, start re-accepted only after abort drops.
REQ-037 Macro defined, preset=8'hFC up, abort after 3 terminal events -> three LOAD pulses after each terminal, wraps=3, done never asserted.
REQ-038 start pulsed during SETTLE with preset=8'h11 -> ignored; cnt_p holds the original value.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a cascaded pair of 74169 up/down counters: load, settle, run until terminal count.
// Define COUNTER_SEQ_AUTO_RELOAD_EN to reload and restart on every terminal event instead of finishing.
module counter_seq_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dir_req,
    input  logic [7:0] preset,
    input  logic       cnt_rco_n,
    output logic       cnt_load_n,
    output logic       cnt_ent_n,
    output logic       cnt_enp_n,
    output logic       cnt_dir,
    output logic [7:0] cnt_p,
    output logic       busy,
    output logic       done,
    output logic [7:0] wraps
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       terminal;

    // The counter pulls RCO low while loading, so it only means terminal count in RUN.
    assign terminal = (state == RUN) && !cnt_rco_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            cnt_load_n <= 1'b1;
            cnt_ent_n  <= 1'b1;
            cnt_enp_n  <= 1'b1;
            cnt_dir    <= 1'b1;
            cnt_p      <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            wraps      <= 8'h00;
        end else begin
            // A terminal event is counted even when abort wins the state transition.
            if (terminal && (wraps != 8'hFF)) begin
                wraps <= wraps + 8'd1;
            end

            if (abort) begin
                state      <= IDLE;
                settle_cnt <= 4'd0;
                cnt_load_n <= 1'b1;
                cnt_ent_n  <= 1'b1;
                cnt_enp_n  <= 1'b1;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        done <= 1'b0;
                        if (start) begin
                            cnt_p      <= preset;
                            cnt_dir    <= dir_req;
                            wraps      <= 8'h00;
                            cnt_load_n <= 1'b0;
                            busy       <= 1'b1;
                            state      <= LOAD;
                        end
                    end

                    LOAD: begin
                        cnt_load_n <= 1'b1;
                        settle_cnt <= SETTLE_LAST;
                        state      <= SETTLE;
                    end

                    SETTLE: begin
                        if (settle_cnt == 4'd0) begin
                            cnt_ent_n <= 1'b0;
                            cnt_enp_n <= 1'b0;
                            state     <= RUN;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end

                    RUN: begin
                        if (terminal) begin
                            cnt_ent_n <= 1'b1;
                            cnt_enp_n <= 1'b1;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                            cnt_load_n <= 1'b0;
                            state      <= LOAD;
`else
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end
                    end

                    DONE: begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end

                    default: begin
                        cnt_load_n <= 1'b1;
                        cnt_ent_n  <= 1'b1;
                        cnt_enp_n  <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        state      <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural model of the cascaded 74169 pair.
// Sections guarded by COUNTER_SEQ_AUTO_RELOAD_EN follow the build configuration of the design.
module tb_counter_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dir_req;
    logic [7:0] preset;
    logic       cnt_rco_n;
    logic       cnt_load_n;
    logic       cnt_ent_n;
    logic       cnt_enp_n;
    logic       cnt_dir;
    logic [7:0] cnt_p;
    logic       busy;
    logic       done;
    logic [7:0] wraps;

    int total = 0;
    int bad   = 0;

    logic       use_model;
    logic       rco_force;
    logic [7:0] model_cnt;
    logic       model_rco_n;

    counter_seq_ctrl #(.SETTLE_CYCLES(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .dir_req    (dir_req),
        .preset     (preset),
        .cnt_rco_n  (cnt_rco_n),
        .cnt_load_n (cnt_load_n),
        .cnt_ent_n  (cnt_ent_n),
        .cnt_enp_n  (cnt_enp_n),
        .cnt_dir    (cnt_dir),
        .cnt_p      (cnt_p),
        .busy       (busy),
        .done       (done),
        .wraps      (wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cascaded counter: RCO low at 8'hFF up / 8'h00 down with ENT low, and forced low while loading.
    always @(posedge clk) begin
        if (!cnt_load_n)
            model_cnt <= cnt_p;
        else if (!cnt_ent_n && !cnt_enp_n)
            model_cnt <= cnt_dir ? model_cnt + 8'd1 : model_cnt - 8'd1;
    end

    assign model_rco_n = !cnt_load_n ? 1'b0 :
                         !(!cnt_ent_n && (cnt_dir ? (model_cnt == 8'hFF) : (model_cnt == 8'h00)));
    assign cnt_rco_n   = use_model ? model_rco_n : rco_force;

    task automatic applyStimulus(input logic s, input logic a, input logic d, input logic [7:0] p);
        start   = s;
        abort   = a;
        dir_req = d;
        preset  = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int n;
        int loads;
        logic seen_done;

        rst_n     = 1'b1;
        use_model = 1'b1;
        rco_force = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_load_n", {7'd0, cnt_load_n}, 8'd1);
        checkOutput("rst_ent_n",  {7'd0, cnt_ent_n},  8'd1);
        checkOutput("rst_enp_n",  {7'd0, cnt_enp_n},  8'd1);
        checkOutput("rst_dir",    {7'd0, cnt_dir},    8'd1);
        checkOutput("rst_p",      cnt_p,              8'h00);
        checkOutput("rst_busy",   {7'd0, busy},       8'd0);
        checkOutput("rst_done",   {7'd0, done},       8'd0);
        checkOutput("rst_wraps",  wraps,              8'h00);

        // Release reset with start already high: the first live edge must accept it once.
        #10;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hF0);
        tick();
        checkOutput("f0_load_n", {7'd0, cnt_load_n}, 8'd0);
        checkOutput("f0_busy",   {7'd0, busy},       8'd1);
        checkOutput("f0_p",      cnt_p,              8'hF0);
        checkOutput("f0_ent_ld", {7'd0, cnt_ent_n},  8'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hF0);
        tick();
        checkOutput("f0_settle_load_n", {7'd0, cnt_load_n}, 8'd1);
        checkOutput("f0_settle_ent",    {7'd0, cnt_ent_n},  8'd1);
        tick();
        checkOutput("f0_run_ent", {7'd0, cnt_ent_n}, 8'd0);
        checkOutput("f0_run_enp", {7'd0, cnt_enp_n}, 8'd0);
`ifndef COUNTER_SEQ_AUTO_RELOAD_EN
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("f0_run_cycles", 8'(n), 8'd16);
        checkOutput("f0_wraps",      wraps, 8'd1);
        checkOutput("f0_done_ent",   {7'd0, cnt_ent_n}, 8'd1);
        tick();
        checkOutput("f0_done_clr", {7'd0, done}, 8'd0);
        checkOutput("f0_idle",     {7'd0, busy}, 8'd0);

        // Preset 8'hFF counting up hits terminal count on the first RUN edge.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        tick();
        tick();
        checkOutput("ff_run_wraps", wraps, 8'd0);
        tick();
        checkOutput("ff_done",  {7'd0, done}, 8'd1);
        checkOutput("ff_wraps", wraps,        8'd1);
        tick();
        checkOutput("ff_idle", {7'd0, busy}, 8'd0);
`else
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hF0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hF0);
        checkOutput("f0_abort_busy", {7'd0, busy}, 8'd0);
`endif

        // Abort in the 5th RUN cycle while start stays high.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h10);
        tick();
        tick();
        tick();
        repeat (4) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h10);
        tick();
        checkOutput("ab_busy",   {7'd0, busy},       8'd0);
        checkOutput("ab_ent",    {7'd0, cnt_ent_n},  8'd1);
        checkOutput("ab_enp",    {7'd0, cnt_enp_n},  8'd1);
        checkOutput("ab_load_n", {7'd0, cnt_load_n}, 8'd1);
        checkOutput("ab_done",   {7'd0, done},       8'd0);
        tick();
        checkOutput("ab_held_busy",   {7'd0, busy},       8'd0);
        checkOutput("ab_held_load_n", {7'd0, cnt_load_n}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h10);
        tick();
        checkOutput("ab_restart_load_n", {7'd0, cnt_load_n}, 8'd0);
        checkOutput("ab_restart_busy",   {7'd0, busy},       8'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h10);
        tick();
        checkOutput("ab2_busy", {7'd0, busy}, 8'd0);

        // RCO held low throughout: ignored in LOAD/SETTLE, counted in RUN even as abort wins.
        use_model = 1'b0;
        rco_force = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h50);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h50);
        tick();
        tick();
        checkOutput("rco_ign_wraps", wraps,              8'd0);
        checkOutput("rco_ign_ent",   {7'd0, cnt_ent_n},  8'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h50);
        tick();
        checkOutput("rco_ab_wraps", wraps,        8'd1);
        checkOutput("rco_ab_busy",  {7'd0, busy}, 8'd0);
        checkOutput("rco_ab_done",  {7'd0, done}, 8'd0);
        use_model = 1'b1;
        rco_force = 1'b1;

        // Start pulsed during SETTLE with a different preset and direction.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h22);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h22);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
        tick();
        checkOutput("st_p",      cnt_p,              8'h22);
        checkOutput("st_dir",    {7'd0, cnt_dir},    8'd0);
        checkOutput("st_load_n", {7'd0, cnt_load_n}, 8'd1);
        checkOutput("st_ent",    {7'd0, cnt_ent_n},  8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h11);
`ifndef COUNTER_SEQ_AUTO_RELOAD_EN
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checkOutput("down_run_cycles", 8'(n), 8'd35);
        checkOutput("down_wraps",      wraps, 8'd1);
        tick();
`else
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h11);
`endif

        // Asynchronous reset pulse in the middle of RUN.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h40);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h40);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        checkOutput("mid_rst_busy",   {7'd0, busy},       8'd0);
        checkOutput("mid_rst_ent",    {7'd0, cnt_ent_n},  8'd1);
        checkOutput("mid_rst_enp",    {7'd0, cnt_enp_n},  8'd1);
        checkOutput("mid_rst_load_n", {7'd0, cnt_load_n}, 8'd1);
        checkOutput("mid_rst_dir",    {7'd0, cnt_dir},    8'd1);
        checkOutput("mid_rst_p",      cnt_p,              8'h00);
        checkOutput("mid_rst_wraps",  wraps,              8'h00);
        tick();
        checkOutput("post_rst_busy", {7'd0, busy}, 8'd0);

`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
        // Auto-reload: every terminal event reloads 8'hFC and counts on.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFC);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFC);
        loads     = 0;
        seen_done = 1'b0;
        n         = 0;
        while (wraps !== 8'd3 && n < 100) begin
            tick();
            n++;
            if (cnt_load_n === 1'b0) loads++;
            if (done === 1'b1) seen_done = 1'b1;
        end
        checkOutput("ar_reloads", 8'(loads),        8'd3);
        checkOutput("ar_ticks",   8'(n),            8'd18);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFC);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFC);
        checkOutput("ar_busy",    {7'd0, busy},      8'd0);
        checkOutput("ar_wraps",   wraps,             8'd3);
        checkOutput("ar_no_done", {7'd0, seen_done}, 8'd0);
`else
        loads     = 0;
        seen_done = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
